emg_iir_sched: RTL
==================

EMG_IIR_SCHED -- requirements
Module: emg_iir_sched

Interface
REQ-001 SHALL have parameter NCH, default 4, giving the number of EMG channels sharing one floating-point multiply-accumulate datapath.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: the only reset; asynchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit: request one filter update of all channels; sampled only in IDLE.
REQ-005 SHALL have port spike_cnt, input, NCH*32 bits: unsigned integer spike count per channel, with channel c at bits [32c+31:32c].
REQ-006 SHALL have port coef_we, input, 1 bit: coefficient write strobe.
REQ-007 SHALL have port coef_sel, input, 3 bits: coefficient index, 0=b1, 1=b2, 2=a1, 3=a2, 4=a3.
REQ-008 SHALL have port coef_data, input, 32 bits: IEEE-754 single-precision coefficient value.
REQ-009 SHALL have port busy, output, 1 bit: high while an update is in progress.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse when all channels have been updated.
REQ-011 SHALL have port emg_out, output, NCH*32 bits: IEEE-754 single-precision filter output per channel, packed like spike_cnt.

Function
REQ-012 SHALL compute, per channel, y[n] = b1*x[n-1] + b2*x[n-2] - a1*y[n-1] - a2*y[n-2] - a3*y[n-3].
- x = float(spike_cnt).
REQ-013 SHALL implement an FSM with states IDLE, MAC and WB.
REQ-014 In IDLE, on an edge where start=1, the block SHALL:
- convert all spike_cnt words to float and hold them in x_cur[c];
- copy the shadow coefficients into the active coefficients;
- clear acc to 32'h00000000;
- set ch=0, k=0;
- go to MAC.
REQ-015 In MAC, each edge SHALL perform acc <= fp_add(acc, fp_mult(coef_k, hist_k)) for term k.
- Terms in fixed order: k=0 b1*x1, k=1 b2*x2, k=2 (-a1)*y1, k=3 (-a2)*y2, k=4 (-a3)*y3.
- Negate a coefficient by inverting its sign bit.
- After the k=4 edge, go to WB.
REQ-016 In WB, one edge SHALL update channel ch as follows:
- emg_out[ch] <= acc, y1 <= acc, y2 <= y1, y3 <= y2;
- x1 <= x_cur[ch], x2 <= x1;
- clear acc.
- If ch=NCH-1, go to IDLE and pulse done; otherwise ch <= ch+1, k <= 0, go to MAC.
REQ-017 Timing SHALL be fixed: each channel takes 6 cycles.
- busy is high from the edge that accepts start until the final WB edge, i.e. 6*NCH cycles.
- done is high for exactly the single cycle after the final WB edge.
REQ-018 start SHALL be ignored while busy=1.
- start may be accepted in the same cycle that done=1, because the FSM is then in IDLE.
REQ-019 coef_we=1 SHALL write coef_data into the shadow coefficient selected by coef_sel, in any state.
- coef_sel values 5..7 SHALL be ignored.
- Shadow coefficients take effect only at the next accepted start.
REQ-020 emg_out[c] SHALL change only in channel c's WB cycle and hold its value otherwise.
REQ-021 Spike counts SHALL be converted from unsigned 32-bit integer to float using round-to-nearest-even; spike_cnt changes during busy SHALL have no effect.
REQ-022 The floating-point mult and add SHALL be combinational IEEE-754 single-precision units, so every MAC cycle completes in one clock.

Reset
REQ-023 reset_n=0 SHALL immediately perform the following, including mid-operation with no partial write-back:
- force the FSM to IDLE;
- clear busy and done;
- clear ch, k and acc;
- clear all emg_out words, x/y histories, x_cur, shadow coefficients and active coefficients to 32'h00000000.
REQ-024 After reset release, the first accepted start SHALL behave as described in REQ-014 to REQ-017.

Structure
REQ-025 A shared package emg_sched_pkg SHALL hold:
- the FSM state enum;
- the coefficient index constants B1..A3;
- FP_ZERO = 32'h00000000;
- the terms-per-channel constant NTERM = 5.
REQ-026 A single sub-module, emg_fp_mac, SHALL wrap one fp mult and one fp add (out = acc + a*b); all sequencing and history storage SHALL remain in emg_iir_sched.

Verification
REQ-027 Impulse on b1: b1=1.0, other coefficients 0, spike_cnt ch0=5.
- First start -> emg_out ch0 = 0.0.
- Second start -> emg_out ch0 = 5.0 (40A00000).
- Third start with spike_cnt=0 -> emg_out ch0 = 5.0.
REQ-028 Recursion: b1=1.0, a1=-0.5, x ch1 = 2 then 0.
- Successive starts -> emg_out ch1 = 0.0, 2.0, 1.0, 0.5.
REQ-029 Timing with NCH=4: start pulse -> busy high for 24 cycles, done high for 1 cycle, emg_out[c] updates at cycle 6c+6 after the start edge.
REQ-030 Guards:
- start asserted during busy -> ignored, still exactly one done pulse.
- coef_we during busy -> the current update uses the old coefficients, the next update uses the new ones.
- coef_sel=7 -> no coefficient changes.
REQ-031 Reset mid-operation: reset_n=0 at cycle 10 of an update -> busy=0, done=0, all emg_out words 0, histories cleared; a following start reproduces the REQ-027 results.

Source files
------------

// File: rtl/emg_sched_pkg.sv
// rtl/emg_sched_pkg.sv - shared types, constants and helpers for the EMG IIR scheduler
// Purpose: FSM state enum, coefficient indices, FP constants, leading-one and
//          unsigned-to-float helpers used by emg_iir_sched and emg_fp_mac.
// Ports:   none (package).
package emg_sched_pkg;

  typedef enum logic [1:0] {IDLE, MAC, WB} state_t;

  localparam logic [2:0]  B1      = 3'd0;
  localparam logic [2:0]  B2      = 3'd1;
  localparam logic [2:0]  A1      = 3'd2;
  localparam logic [2:0]  A2      = 3'd3;
  localparam logic [2:0]  A3      = 3'd4;
  localparam logic [31:0] FP_ZERO = 32'h0000_0000;
  localparam int          NTERM   = 5;

  // Index of the highest set bit (0 when v is zero).
  function automatic logic [4:0] msb_pos(input logic [31:0] v);
    msb_pos = 5'd0;
    for (int i = 0; i < 32; i++)
      if (v[i]) msb_pos = 5'(i);
  endfunction

  // Unsigned 32-bit integer to single precision, round-to-nearest-even.
  function automatic logic [31:0] u32_to_fp(input logic [31:0] u);
    logic [4:0]  p;
    logic [30:0] n;
    logic [31:0] r;
    if (u == 32'd0) return FP_ZERO;
    p = msb_pos(u);
    // Left-justify so the implicit one falls off the top; bits below 8 round.
    n = 31'(u << (5'd31 - p));
    r = {1'b0, 8'(8'd127 + {3'b000, p}), n[30:8]};
    // Mantissa carry-out simply bumps the exponent field.
    if (n[7] && ((|n[6:0]) || n[8])) r = r + 32'd1;
    return r;
  endfunction

endpackage

// File: rtl/emg_fp_mac.sv
// rtl/emg_fp_mac.sv - combinational single-precision multiply-accumulate
// Purpose: out = acc + a*b using one fp multiply and one fp add, each RNE.
//          Subnormals flush to zero; overflow saturates to infinity.
// Ports:   acc, a, b - IEEE-754 single operands; out - IEEE-754 single result.
module emg_fp_mac (
  input  logic [31:0] acc,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] out
);
  import emg_sched_pkg::*;

  function automatic logic [31:0] fp_mul(input logic [31:0] x, input logic [31:0] y);
    logic              s, g, st;
    logic [47:0]       pr;
    logic signed [9:0] e;
    logic [22:0]       m;
    logic [31:0]       r;
    s = x[31] ^ y[31];
    if (x[30:23] == 8'd0 || y[30:23] == 8'd0) return {s, 31'd0};
    pr = 48'({1'b1, x[22:0]}) * 48'({1'b1, y[22:0]});
    e  = $signed({2'b00, x[30:23]}) + $signed({2'b00, y[30:23]}) - 10'sd127;
    if (pr[47]) begin
      m = pr[46:24]; g = pr[23]; st = |pr[22:0]; e = e + 10'sd1;
    end else begin
      m = pr[45:23]; g = pr[22]; st = |pr[21:0];
    end
    if (e <= 10'sd0) return {s, 31'd0};
    r = {e[8:0], m};
    if (g && (st || m[0])) r = r + 32'd1;
    if (r[31:23] >= 9'd255) return {s, 8'hFF, 23'd0};
    return {s, r[30:0]};
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] x, input logic [31:0] y);
    logic [31:0]       big, sml, r;
    logic [7:0]        d;
    logic [26:0]       mb, ms, al, n;
    logic [53:0]       ext;
    logic [27:0]       s;
    logic [4:0]        p;
    logic signed [9:0] e;
    // Order by magnitude so the subtraction below never goes negative.
    if (x[30:0] >= y[30:0]) begin big = x; sml = y; end
    else begin big = y; sml = x; end
    if (big[30:23] == 8'd0) return FP_ZERO;
    // Three extra low bits give guard/round/sticky after alignment.
    mb = {1'b1, big[22:0], 3'b000};
    ms = (sml[30:23] == 8'd0) ? 27'd0 : {1'b1, sml[22:0], 3'b000};
    d  = big[30:23] - sml[30:23];
    if (d > 8'd27) al = {26'd0, |ms};
    else begin
      ext = {ms, 27'd0} >> d;
      al  = ext[53:27] | {26'd0, |ext[26:0]};
    end
    s = (big[31] == sml[31]) ? ({1'b0, mb} + {1'b0, al}) : ({1'b0, mb} - {1'b0, al});
    if (s == 28'd0) return FP_ZERO;
    p = msb_pos({4'd0, s});
    n = 27'(s << (5'd27 - p));
    e = $signed({2'b00, big[30:23]}) + $signed({5'd0, p}) - 10'sd26;
    if (e <= 10'sd0) return {big[31], 31'd0};
    r = {e[8:0], n[26:4]};
    if (n[3] && ((|n[2:0]) || n[4])) r = r + 32'd1;
    if (r[31:23] >= 9'd255) return {big[31], 8'hFF, 23'd0};
    return {big[31], r[30:0]};
  endfunction

  always_comb out = fp_add(acc, fp_mul(a, b));

endmodule

// File: rtl/emg_iir_sched.sv
// rtl/emg_iir_sched.sv - shared-MAC scheduler updating NCH EMG IIR filters
// Purpose: on start, runs y = b1*x1 + b2*x2 - a1*y1 - a2*y2 - a3*y3 for every
//          channel through one fp MAC, 5 MAC cycles + 1 write-back per channel.
// Ports:   clk, reset_n (async, active-low); start; spike_cnt (NCH x u32);
//          coef_we/coef_sel/coef_data (shadow coefficient write);
//          busy, done (1-cycle pulse), emg_out (NCH x float32).
module emg_iir_sched #(
  parameter int NCH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [NCH*32-1:0] spike_cnt,
  input  logic              coef_we,
  input  logic [2:0]        coef_sel,
  input  logic [31:0]       coef_data,
  output logic              busy,
  output logic              done,
  output logic [NCH*32-1:0] emg_out
);
  import emg_sched_pkg::*;

  localparam int            CW      = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] CH_LAST = CW'(NCH - 1);
  localparam logic [2:0]    K_LAST  = 3'(NTERM - 1);

  state_t        state;
  logic [CW-1:0] ch;
  logic [2:0]    k;
  logic [31:0]   acc, coef_k, hist_k, mac_out;
  logic [31:0]   coef_sh  [NTERM];
  logic [31:0]   coef_act [NTERM];
  logic [31:0]   x_cur [NCH];
  logic [31:0]   x1 [NCH];
  logic [31:0]   x2 [NCH];
  logic [31:0]   y1 [NCH];
  logic [31:0]   y2 [NCH];
  logic [31:0]   y3 [NCH];

  // Term selection; feedback coefficients enter with their sign bit flipped.
  always_comb begin
    coef_k = FP_ZERO;
    hist_k = FP_ZERO;
    case (k)
      3'd0: begin coef_k = coef_act[B1]; hist_k = x1[ch]; end
      3'd1: begin coef_k = coef_act[B2]; hist_k = x2[ch]; end
      3'd2: begin coef_k = {~coef_act[A1][31], coef_act[A1][30:0]}; hist_k = y1[ch]; end
      3'd3: begin coef_k = {~coef_act[A2][31], coef_act[A2][30:0]}; hist_k = y2[ch]; end
      3'd4: begin coef_k = {~coef_act[A3][31], coef_act[A3][30:0]}; hist_k = y3[ch]; end
      default: ;
    endcase
  end

  emg_fp_mac u_mac (
    .acc (acc),
    .a   (coef_k),
    .b   (hist_k),
    .out (mac_out)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      ch      <= '0;
      k       <= '0;
      acc     <= FP_ZERO;
      emg_out <= '0;
      for (int i = 0; i < NTERM; i++) begin
        coef_sh[i]  <= FP_ZERO;
        coef_act[i] <= FP_ZERO;
      end
      for (int c = 0; c < NCH; c++) begin
        x_cur[c] <= FP_ZERO;
        x1[c]    <= FP_ZERO;
        x2[c]    <= FP_ZERO;
        y1[c]    <= FP_ZERO;
        y2[c]    <= FP_ZERO;
        y3[c]    <= FP_ZERO;
      end
    end else begin
      done <= 1'b0;
      // Shadow writes are accepted in every state; unused indices drop out.
      if (coef_we && coef_sel < 3'(NTERM)) coef_sh[coef_sel] <= coef_data;
      case (state)
        IDLE: begin
          if (start) begin
            // Inputs are captured here so later spike_cnt changes are invisible.
            for (int c = 0; c < NCH; c++) x_cur[c] <= u32_to_fp(spike_cnt[c*32 +: 32]);
            for (int i = 0; i < NTERM; i++) coef_act[i] <= coef_sh[i];
            acc   <= FP_ZERO;
            ch    <= '0;
            k     <= '0;
            busy  <= 1'b1;
            state <= MAC;
          end
        end
        MAC: begin
          acc <= mac_out;
          if (k == K_LAST) state <= WB;
          else             k     <= k + 3'd1;
        end
        WB: begin
          emg_out[int'(ch)*32 +: 32] <= acc;
          y1[ch] <= acc;
          y2[ch] <= y1[ch];
          y3[ch] <= y2[ch];
          x1[ch] <= x_cur[ch];
          x2[ch] <= x1[ch];
          acc    <= FP_ZERO;
          if (ch == CH_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            ch    <= ch + 1'b1;
            k     <= '0;
            state <= MAC;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
